// File: rtl/ch_buf_reader.sv
// Streams a programmed run of words out of the channel buffer read port: first o_valid RD_LAT+2 clocks after start.
// Full backpressure on i_ready. Reads are credit-gated so the output skid FIFO never overflows.

module ch_buf_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wr_vld,
   input  logic [W-1:0]             wr_dat,
   input  logic                     rd_rdy,
   output logic                     rd_vld,
   output logic [W-1:0]             rd_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;

   assign rd_vld = (count != '0);
   assign pop    = rd_rdy && rd_vld;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_vld && !flush) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(wr_vld) - (AW+1)'(pop);
      end
   end
endmodule

module ch_buf_reader #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [ADDR_W:0]   i_len,
   input  logic              i_abort,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_rdaddress,
   input  logic [DATA_W-1:0] i_q,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready
);
   localparam int CW    = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   issue_left;
   logic [ADDR_W:0]   out_left;
   // bit 0: address just registered onto o_rdaddress; bit RD_LAT: i_q holds that word now
   logic [RD_LAT:0]   pipe;
   logic [CW:0]       fifo_cnt;
   logic [OCC_W-1:0]  inflight;
   logic [OCC_W-1:0]  occ;
   logic              fifo_vld;
   logic [DATA_W-1:0] fifo_dat;
   logic              xfer;
   logic              issue;
   logic              start_go;
   logic              done_nxt;

   assign xfer     = fifo_vld && i_ready;
   assign start_go = (state == IDLE) && i_start && (i_len != '0) && !i_abort;

   always_comb begin
      inflight = '0;
      for (int i = 0; i <= RD_LAT; i++) inflight = inflight + OCC_W'(pipe[i]);
   end

   // A word leaving this cycle frees its slot in time for a read issued now.
   assign occ   = OCC_W'(fifo_cnt) + inflight - OCC_W'(xfer);
   assign issue = (state == READ) && (issue_left != '0) && (occ < OCC_W'(FIFO_DEPTH)) && !i_abort;

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    if (start_go) state_nxt = READ;
         READ:    if (issue && issue_left == (ADDR_W+1)'(1)) state_nxt = DRAIN;
         DRAIN:   if (xfer && out_left == (ADDR_W+1)'(1)) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
         default: state_nxt = IDLE;
      endcase
      if (i_abort) begin
         state_nxt = IDLE;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr        <= '0;
         issue_left  <= '0;
         out_left    <= '0;
         pipe        <= '0;
         o_rdaddress <= '0;
         o_done      <= 1'b0;
      end else begin
         o_done <= done_nxt;
         pipe   <= i_abort ? '0 : {pipe[RD_LAT-1:0], issue};
         if (start_go) begin
            addr       <= i_start_addr;
            issue_left <= i_len;
            out_left   <= i_len;
         end else begin
            if (issue) begin
               o_rdaddress <= addr;
               addr        <= addr + ADDR_W'(1);
               issue_left  <= issue_left - (ADDR_W+1)'(1);
            end
            if (xfer && state != IDLE) out_left <= out_left - (ADDR_W+1)'(1);
         end
      end
   end

   ch_buf_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (i_abort),
      .wr_vld (pipe[RD_LAT]),
      .wr_dat (i_q),
      .rd_rdy (i_ready),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .count  (fifo_cnt)
   );

   assign o_busy  = (state != IDLE);
   assign o_valid = fifo_vld;
   assign o_data  = fifo_vld ? fifo_dat : '0;
endmodule

// File: tb/tb_ch_buf_reader.sv
// Bench for ch_buf_reader: one instance with RD_LAT=1 and one with RD_LAT=2, each behind a RAM model holding word[n]=n.
// A scoreboard queue holds expected stream words; the negedge monitor pops and compares every transfer.
module tb_ch_buf_reader;
   localparam int AW = 11;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]         start, abort, ready, busy, done, valid;
   logic [1:0][AW-1:0] start_addr, rdaddr;
   logic [1:0][AW:0]   len;
   logic [1:0][DW-1:0] q, data;

   int checks = 0;
   int failures = 0;
   int cur = 0;
   int xfer_total = 0;
   logic [DW-1:0] sbq[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [DW-1:0] q1, q2;
      int occ_max = 0;
      always @(posedge clk) begin
         q1 <= DW'(rdaddr[g]);
         q2 <= q1;
      end
      assign q[g] = (g == 0) ? q1 : q2;
      always @(negedge clk) if (int'(dut.fifo_cnt) > occ_max) occ_max = int'(dut.fifo_cnt);

      ch_buf_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1), .FIFO_DEPTH(4)) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_start      (start[g]),
         .i_start_addr (start_addr[g]),
         .i_len        (len[g]),
         .i_abort      (abort[g]),
         .o_busy       (busy[g]),
         .o_done       (done[g]),
         .o_rdaddress  (rdaddr[g]),
         .i_q          (q[g]),
         .o_data       (data[g]),
         .o_valid      (valid[g]),
         .i_ready      (ready[g])
      );
   end

   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_dat = '0;
   always @(negedge clk) begin
      if (prev_hold) begin
         chk("hold_vld", 32'(valid[cur]), 1);
         chk("hold_dat", data[cur], prev_dat);
      end
      if (valid[cur] && ready[cur]) begin
         if (sbq.size() == 0) chk("extra_word", data[cur] + 32'd1, 32'd0);
         else                 chk("data", data[cur], sbq.pop_front());
         xfer_total++;
      end
      prev_hold = valid[cur] && !ready[cur] && !abort[cur] && rst_n;
      prev_dat  = data[cur];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready high; mode 1: ready toggles with a 20-cycle stall. inj: extra start pulse while busy.
   task automatic run(input int k, input int a, input int n, input int mode, input bit inj,
                      output int fv, output int dc);
      int c;
      fv = -1;
      dc = -1;
      for (int i = 0; i < n; i++) sbq.push_back(32'((a + i) % 2048));
      start[k] = 1'b1;
      start_addr[k] = AW'(a);
      len[k] = (AW+1)'(n);
      ready[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      c = 0;
      while (c < 6000 && dc < 0) begin
         ready[k] = (mode == 0) ? 1'b1 : ((c >= 12 && c < 32) ? 1'b0 : (c % 2 == 0));
         start[k] = inj && (c == 3);
         if (inj && c == 3) begin
            start_addr[k] = AW'(500);
            len[k] = (AW+1)'(3);
         end
         if (c == 0) chk("busy_c0", 32'(busy[k]), 1);
         if (c == 1) chk("rdaddr_c1", 32'(rdaddr[k]), 32'(a));
         if (valid[k] && fv < 0) fv = c;
         if (done[k]) dc = c;
         else begin
            tick();
            c++;
         end
      end
      start[k] = 1'b0;
      ready[k] = 1'b1;
      chk("busy_at_done", 32'(busy[k]), 0);
      chk("sb_empty", 32'(sbq.size()), 0);
      tick();
      chk("done_pulse", 32'(done[k]), 0);
   endtask

   task automatic abort_scn(input int k);
      int base, c, seen, fv, dc;
      base = xfer_total;
      for (int i = 0; i < 32; i++) sbq.push_back(32'(i));
      start[k] = 1'b1;
      start_addr[k] = '0;
      len[k] = (AW+1)'(32);
      ready[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      c = 0;
      while (xfer_total - base < 5 && c < 200) begin
         tick();
         c++;
      end
      ready[k] = 1'b0;
      abort[k] = 1'b1;
      tick();
      abort[k] = 1'b0;
      chk("ab_xfers", 32'(xfer_total - base), 5);
      chk("ab_valid", 32'(valid[k]), 0);
      chk("ab_busy", 32'(busy[k]), 0);
      sbq.delete();
      ready[k] = 1'b1;
      seen = 0;
      repeat (12) begin
         if (done[k] || valid[k] || busy[k]) seen++;
         tick();
      end
      chk("ab_quiet", 32'(seen), 0);
      run(k, 100, 2, 0, 1'b0, fv, dc);
      chk("ab_rerun_done", 32'(dc), 32'(2 + k + 1 + 2));
   endtask

   initial begin
      int fv, dc, seen, L, om;
      start = '0; abort = '0; ready = '0; start_addr = '0; len = '0;
      rst_n = 1'b0;
      #23;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_rdaddr", 32'(rdaddr[0]) | 32'(rdaddr[1]), 0);
      chk("rst_data", data[0] | data[1], 0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 2; k++) begin
         cur = k;
         L = k + 1;
         tick();
         run(k, 0, 8, 0, 1'b0, fv, dc);
         chk("s1_first_vld", 32'(fv), 32'(L + 2));
         chk("s1_done_cyc", 32'(dc), 32'(L + 10));

         run(k, 2044, 8, 0, 1'b0, fv, dc);
         chk("wrap_done_cyc", 32'(dc), 32'(L + 10));

         run(k, 40, 16, 1, 1'b0, fv, dc);
         chk("bp_done_seen", 32'(dc >= 0), 1);

         abort_scn(k);

         start[k] = 1'b1;
         start_addr[k] = AW'(7);
         len[k] = '0;
         tick();
         start[k] = 1'b0;
         seen = 0;
         repeat (8) begin
            if (busy[k] || done[k] || valid[k]) seen++;
            tick();
         end
         chk("len0_noop", 32'(seen), 0);

         run(k, 300, 8, 0, 1'b1, fv, dc);
         chk("busy_start_done", 32'(dc), 32'(L + 10));

         run(k, 1, 2048, 0, 1'b0, fv, dc);
         chk("full_done_cyc", 32'(dc), 32'(2048 + L + 2));

         om = (k == 0) ? g_dut[0].occ_max : g_dut[1].occ_max;
         chk("fifo_occ_le4", 32'(om <= 4), 1);
      end

      cur = 1;
      for (int i = 0; i < 16; i++) sbq.push_back(32'(i));
      start[1] = 1'b1;
      start_addr[1] = '0;
      len[1] = (AW+1)'(16);
      ready[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      repeat (7) tick();
      chk("pre_rst_busy", 32'(busy[1]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_valid", 32'(valid), 0);
      chk("arst_rdaddr", 32'(rdaddr[1]), 0);
      chk("arst_data", data[1], 0);
      sbq.delete();
      #10;
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
